// File: rtl/vx_lane_serializer_pkg.sv
// Shared constants for the lane serializer: FSM encoding, scan operator codes
// and the lane-index width helper.
package vx_lane_serializer_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int SCAN_OP_XOR = 0;
  localparam int SCAN_OP_AND = 1;
  localparam int SCAN_OP_OR  = 2;

  // A single lane still needs a one-bit index field.
  function automatic int lane_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/VX_onehot_encoder.sv
// One-hot to binary encoder; the input is expected to carry at most one set bit.
module VX_onehot_encoder
  import vx_lane_serializer_pkg::*;
#(
  parameter int N  = 1,
  parameter int LN = lane_bits(N)
) (
  input  logic [N-1:0]  data_in,
  output logic [LN-1:0] data_out
);

  always_comb begin
    data_out = '0;
    for (int i = 0; i < N; i++) begin
      if (data_in[i]) data_out = data_out | LN'(i);
    end
  end

endmodule

// File: rtl/VX_scan.sv
// Inclusive prefix scan (XOR/AND/OR) across a bit vector, low to high unless
// REVERSE is set.
module VX_scan
  import vx_lane_serializer_pkg::*;
#(
  parameter int N       = 1,
  parameter int OP      = SCAN_OP_XOR,
  parameter int REVERSE = 0
) (
  input  logic [N-1:0] data_in,
  output logic [N-1:0] data_out
);

  logic [N-1:0] src;
  logic [N-1:0] res;

  always_comb begin
    src      = '0;
    res      = '0;
    data_out = '0;
    for (int i = 0; i < N; i++) begin
      src[i] = (REVERSE != 0) ? data_in[N-1-i] : data_in[i];
    end
    res[0] = src[0];
    for (int i = 1; i < N; i++) begin
      case (OP)
        SCAN_OP_AND: res[i] = res[i-1] & src[i];
        SCAN_OP_OR:  res[i] = res[i-1] | src[i];
        default:     res[i] = res[i-1] ^ src[i];
      endcase
    end
    for (int i = 0; i < N; i++) begin
      data_out[i] = (REVERSE != 0) ? res[N-1-i] : res[i];
    end
  end

endmodule

// File: rtl/vx_lane_serializer.sv
// Serializes the active lanes of one multi-lane request into a valid/ready
// beat stream, lowest lane first, with sop/eop framing and a beat counter.
module vx_lane_serializer
  import vx_lane_serializer_pkg::*;
#(
  parameter  int NUM_LANES  = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int LANE_BITS  = lane_bits(NUM_LANES)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            valid_in,
  input  logic [NUM_LANES-1:0]            mask_in,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
  output logic                            ready_in,
  output logic                            valid_out,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic [LANE_BITS-1:0]            lane_out,
  output logic [LANE_BITS-1:0]            beat_out,
  output logic                            sop_out,
  output logic                            eop_out,
  input  logic                            ready_out
);

  // Handshake rule (both sides): a transfer happens on a rising clk edge where
  // valid and ready are both high; valid holds with stable payload until then.

  logic [0:0]                      busy;
  logic [NUM_LANES-1:0]            pending;
  logic [LANE_BITS-1:0]            beat;
  logic [NUM_LANES*DATA_WIDTH-1:0] data_q;

  logic [NUM_LANES-1:0] prefix;
  logic [NUM_LANES-1:0] onehot;
  logic [NUM_LANES-1:0] remaining;
  logic                 fire_in;
  logic                 fire_out;
  logic                 last_fire;
  logic                 load;

  VX_scan #(
    .N       (NUM_LANES),
    .OP      (SCAN_OP_OR),
    .REVERSE (0)
  ) u_scan (
    .data_in  (pending),
    .data_out (prefix)
  );

  // The first set bit of the OR-scan marks the lowest pending lane.
  assign onehot    = prefix & ~(prefix << 1);
  assign remaining = pending & ~onehot;

  VX_onehot_encoder #(
    .N  (NUM_LANES),
    .LN (LANE_BITS)
  ) u_enc (
    .data_in  (onehot),
    .data_out (lane_out)
  );

  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (onehot[i]) data_out = data_out | data_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign valid_out = (busy == ST_BUSY);
  assign eop_out   = valid_out & (remaining == '0);
  assign sop_out   = valid_out & (beat == '0);
  assign beat_out  = beat;

  assign fire_out  = valid_out & ready_out;
  assign last_fire = fire_out & eop_out;
  // Re-arming on the final beat lets a new request follow with no bubble.
  assign ready_in  = reset_n & (~valid_out | last_fire);
  assign fire_in   = valid_in & ready_in;
  assign load      = fire_in & (|mask_in);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= ST_IDLE;
      pending <= '0;
      beat    <= '0;
      data_q  <= '0;
    end else if (load) begin
      busy    <= ST_BUSY;
      pending <= mask_in;
      beat    <= '0;
      data_q  <= data_in;
    end else if (last_fire) begin
      busy    <= ST_IDLE;
      pending <= '0;
      beat    <= '0;
    end else if (fire_out) begin
      pending <= remaining;
      beat    <= beat + LANE_BITS'(1);
    end
  end

endmodule

// File: tb/tb_vx_lane_serializer.sv
// Bench for vx_lane_serializer: 4-lane, 8-lane and 1-lane instances, directed
// corner sequences, vector tables and a randomized scoreboard run.
module tb_vx_lane_serializer;

  localparam int DW = 32;

  typedef struct {
    logic [3:0] mask;
    int         exp_beats;
    int         exp_first;
    int         exp_last;
  } req_vec_t;

  typedef struct {
    logic       ready;
    logic [1:0] exp_lane;
    logic [31:0] exp_data;
    logic       exp_eop;
  } bp_vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  int total = 0;
  int bad   = 0;

  // 4-lane instance
  logic         a_valid_in;
  logic [3:0]   a_mask;
  logic [127:0] a_data;
  logic         a_ready_in;
  logic         a_valid_out;
  logic [31:0]  a_data_out;
  logic [1:0]   a_lane;
  logic [1:0]   a_beat;
  logic         a_sop;
  logic         a_eop;
  logic         a_ready_out;
  logic         a_ready_man;
  logic         a_rnd_mode;
  logic         a_rnd_bit;
  assign a_ready_out = a_rnd_mode ? a_rnd_bit : a_ready_man;

  // 8-lane instance
  logic         b_valid_in;
  logic [7:0]   b_mask;
  logic [255:0] b_data;
  logic         b_ready_in;
  logic         b_valid_out;
  logic [31:0]  b_data_out;
  logic [2:0]   b_lane;
  logic [2:0]   b_beat;
  logic         b_sop;
  logic         b_eop;
  logic         b_ready_out;
  logic         b_rnd_bit;
  assign b_ready_out = b_rnd_bit;

  // 1-lane instance
  logic         c_valid_in;
  logic [0:0]   c_mask;
  logic [31:0]  c_data;
  logic         c_ready_in;
  logic         c_valid_out;
  logic [31:0]  c_data_out;
  logic [0:0]   c_lane;
  logic [0:0]   c_beat;
  logic         c_sop;
  logic         c_eop;
  logic         c_ready_out;

  vx_lane_serializer #(.NUM_LANES(4), .DATA_WIDTH(DW)) dut_a (
    .clk(clk), .reset_n(reset_n), .valid_in(a_valid_in), .mask_in(a_mask),
    .data_in(a_data), .ready_in(a_ready_in), .valid_out(a_valid_out),
    .data_out(a_data_out), .lane_out(a_lane), .beat_out(a_beat),
    .sop_out(a_sop), .eop_out(a_eop), .ready_out(a_ready_out)
  );

  vx_lane_serializer #(.NUM_LANES(8), .DATA_WIDTH(DW)) dut_b (
    .clk(clk), .reset_n(reset_n), .valid_in(b_valid_in), .mask_in(b_mask),
    .data_in(b_data), .ready_in(b_ready_in), .valid_out(b_valid_out),
    .data_out(b_data_out), .lane_out(b_lane), .beat_out(b_beat),
    .sop_out(b_sop), .eop_out(b_eop), .ready_out(b_ready_out)
  );

  vx_lane_serializer #(.NUM_LANES(1), .DATA_WIDTH(DW)) dut_c (
    .clk(clk), .reset_n(reset_n), .valid_in(c_valid_in), .mask_in(c_mask),
    .data_in(c_data), .ready_in(c_ready_in), .valid_out(c_valid_out),
    .data_out(c_data_out), .lane_out(c_lane), .beat_out(c_beat),
    .sop_out(c_sop), .eop_out(c_eop), .ready_out(c_ready_out)
  );

  // scoreboard queues: {lane, data, beat, sop, eop}
  logic [37:0] a_exp_q[$];
  logic [39:0] b_exp_q[$];
  int a_beats = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: active lanes in ascending order, beats numbered from 0
  task automatic push_a(input logic [3:0] mask, input logic [127:0] data);
    int n, k;
    n = $countones(mask);
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        a_exp_q.push_back({2'(i), data[i*DW +: DW], 2'(k), (k == 0), (k == n - 1)});
        k++;
      end
    end
  endtask

  task automatic push_b(input logic [7:0] mask, input logic [255:0] data);
    int n, k;
    n = $countones(mask);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        b_exp_q.push_back({3'(i), data[i*DW +: DW], 3'(k), (k == 0), (k == n - 1)});
        k++;
      end
    end
  endtask

  // drivers: hold the request until accepted, then record expected beats
  task automatic drive_a(input logic [3:0] mask, input logic [127:0] data);
    int n;
    n = 0;
    a_valid_in = 1'b1;
    a_mask     = mask;
    a_data     = data;
    do begin
      @(negedge clk);
      n++;
    end while (!a_ready_in && n < 200);
    if (!a_ready_in) begin
      total++;
      bad++;
      $display("FAIL a_accept: ready_in low for %0d cycles, required 1", n);
    end else begin
      push_a(mask, data);
    end
    tick();
    a_valid_in = 1'b0;
  endtask

  task automatic drive_b(input logic [7:0] mask, input logic [255:0] data);
    int n;
    n = 0;
    b_valid_in = 1'b1;
    b_mask     = mask;
    b_data     = data;
    do begin
      @(negedge clk);
      n++;
    end while (!b_ready_in && n < 200);
    if (!b_ready_in) begin
      total++;
      bad++;
      $display("FAIL b_accept: ready_in low for %0d cycles, required 1", n);
    end else begin
      push_b(mask, data);
    end
    tick();
    b_valid_in = 1'b0;
  endtask

  initial begin
    a_rnd_bit = 1'b1;
    b_rnd_bit = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      a_rnd_bit = 1'($urandom_range(0, 1));
      b_rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  // monitors: scoreboard compare on each accepted beat, stability under stall
  function automatic logic [37:0] a_snap();
    return {a_lane, a_data_out, a_beat, a_sop, a_eop};
  endfunction

  function automatic logic [39:0] b_snap();
    return {b_lane, b_data_out, b_beat, b_sop, b_eop};
  endfunction

  initial begin
    logic        a_hold;
    logic [37:0] a_prev;
    a_hold = 1'b0;
    a_prev = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        a_hold = 1'b0;
      end else begin
        if (a_hold) begin
          check("a_stall_valid", a_valid_out, 1'b1);
          check("a_stall_stable", a_snap(), a_prev);
        end
        if (a_valid_out && a_ready_out) begin
          a_beats++;
          if (a_exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL a_beat: unexpected beat lane %0d beat %0d, required none", a_lane, a_beat);
          end else begin
            check("a_beat", a_snap(), a_exp_q.pop_front());
          end
        end
        a_hold = a_valid_out & ~a_ready_out;
        a_prev = a_snap();
      end
    end
  end

  initial begin
    logic        b_hold;
    logic [39:0] b_prev;
    b_hold = 1'b0;
    b_prev = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        b_hold = 1'b0;
      end else begin
        if (b_hold) begin
          check("b_stall_valid", b_valid_out, 1'b1);
          check("b_stall_stable", b_snap(), b_prev);
        end
        if (b_valid_out && b_ready_out) begin
          if (b_exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL b_beat: unexpected beat lane %0d beat %0d, required none", b_lane, b_beat);
          end else begin
            check("b_beat", b_snap(), b_exp_q.pop_front());
          end
        end
        b_hold = b_valid_out & ~b_ready_out;
        b_prev = b_snap();
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    req_vec_t vecs[7];
    bp_vec_t  bp[5];
    int       start, cnt, first, last, n;

    vecs[0] = '{4'b1011, 3, 0, 3};
    vecs[1] = '{4'b0110, 2, 1, 2};
    vecs[2] = '{4'b1000, 1, 3, 3};
    vecs[3] = '{4'b0001, 1, 0, 0};
    vecs[4] = '{4'b1111, 4, 0, 3};
    vecs[5] = '{4'b0101, 2, 0, 2};
    vecs[6] = '{4'b0000, 0, 0, 0};

    bp[0] = '{1'b0, 2'd1, 32'h22, 1'b0};
    bp[1] = '{1'b0, 2'd1, 32'h22, 1'b0};
    bp[2] = '{1'b1, 2'd1, 32'h22, 1'b0};
    bp[3] = '{1'b0, 2'd2, 32'h33, 1'b1};
    bp[4] = '{1'b1, 2'd2, 32'h33, 1'b1};

    reset_n     = 1'b0;
    a_valid_in  = 1'b0; a_mask = '0; a_data = '0;
    b_valid_in  = 1'b0; b_mask = '0; b_data = '0;
    c_valid_in  = 1'b0; c_mask = '0; c_data = '0;
    c_ready_out = 1'b1;
    a_ready_man = 1'b1;
    a_rnd_mode  = 1'b0;

    // reset state
    #3;
    check("rst_valid", a_valid_out, 1'b0);
    check("rst_ready_in", a_ready_in, 1'b0);
    check("rst_sop_eop", {a_sop, a_eop}, 2'b00);
    check("rst_lane_beat", {a_lane, a_beat}, 4'h0);
    check("rst_data", a_data_out, 32'h0);
    check("rst_b_ready_in", b_ready_in, 1'b0);
    check("rst_c_ready_in", c_ready_in, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    tick();
    check("post_rst_ready_in", {a_ready_in, b_ready_in, c_ready_in}, 3'b111);
    check("post_rst_valid", a_valid_out, 1'b0);

    // single request, no backpressure
    drive_a(4'b1011, {32'hD3, 32'hC2, 32'hB1, 32'hA0});
    check("t1_beat0", {a_valid_out, a_lane, a_data_out, a_beat, a_sop, a_eop},
          {1'b1, 2'd0, 32'hA0, 2'd0, 1'b1, 1'b0});
    check("t1_ready_in_mid", a_ready_in, 1'b0);
    tick();
    check("t1_beat1", {a_valid_out, a_lane, a_data_out, a_beat, a_sop, a_eop},
          {1'b1, 2'd1, 32'hB1, 2'd1, 1'b0, 1'b0});
    tick();
    check("t1_beat2", {a_valid_out, a_lane, a_data_out, a_beat, a_sop, a_eop},
          {1'b1, 2'd3, 32'hD3, 2'd2, 1'b0, 1'b1});
    check("t1_ready_in_eop", a_ready_in, 1'b1);
    tick();
    check("t1_idle", a_valid_out, 1'b0);

    // backpressure
    a_ready_man = 1'b0;
    start = a_beats;
    drive_a(4'b0110, {32'h44, 32'h33, 32'h22, 32'h11});
    for (int i = 0; i < 5; i++) begin
      a_ready_man = bp[i].ready;
      check("t2_beat", {a_valid_out, a_lane, a_data_out, a_eop},
            {1'b1, bp[i].exp_lane, bp[i].exp_data, bp[i].exp_eop});
      tick();
    end
    check("t2_idle", a_valid_out, 1'b0);
    check("t2_beat_count", a_beats - start, 2);
    a_ready_man = 1'b1;

    // back-to-back
    drive_a(4'b1000, {32'hA3, 32'h0, 32'h0, 32'h0});
    check("t3_a_eop", {a_valid_out, a_lane, a_sop, a_eop}, {1'b1, 2'd3, 1'b1, 1'b1});
    check("t3_ready_on_last", a_ready_in, 1'b1);
    drive_a(4'b0001, {32'h0, 32'h0, 32'h0, 32'hB0});
    check("t3_b_beat", {a_valid_out, a_lane, a_data_out, a_sop, a_eop},
          {1'b1, 2'd0, 32'hB0, 1'b1, 1'b1});
    tick();
    check("t3_idle", a_valid_out, 1'b0);

    // zero mask
    check("t4_ready_in", a_ready_in, 1'b1);
    drive_a(4'b0000, {32'h1, 32'h2, 32'h3, 32'h4});
    check("t4_no_beat", a_valid_out, 1'b0);
    tick();
    check("t4_no_beat_later", a_valid_out, 1'b0);
    drive_a(4'b0100, {32'h0, 32'h77, 32'h0, 32'h0});
    check("t4_single", {a_valid_out, a_lane, a_data_out, a_sop, a_eop},
          {1'b1, 2'd2, 32'h77, 1'b1, 1'b1});
    tick();
    check("t4_idle", a_valid_out, 1'b0);

    // reset mid-request
    drive_a(4'b1111, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
    tick();
    tick();
    check("t5_third_beat", {a_valid_out, a_lane}, {1'b1, 2'd2});
    #1 reset_n = 1'b0;
    #1;
    check("t5_rst_valid", a_valid_out, 1'b0);
    check("t5_rst_ready_in", a_ready_in, 1'b0);
    a_exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("t5_post_ready_in", a_ready_in, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("t5_no_residual", a_valid_out, 1'b0);
      tick();
    end

    // single-lane instance
    c_valid_in = 1'b1; c_mask = 1'b1; c_data = 32'h5A5A0001;
    check("c_ready_in", c_ready_in, 1'b1);
    tick();
    c_valid_in = 1'b0;
    check("c_beat", {c_valid_out, c_lane, c_beat, c_sop, c_eop, c_data_out},
          {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5A5A0001});
    check("c_ready_on_last", c_ready_in, 1'b1);
    tick();
    check("c_idle", c_valid_out, 1'b0);
    c_valid_in = 1'b1; c_mask = 1'b0;
    tick();
    c_valid_in = 1'b0;
    check("c_zero_mask", c_valid_out, 1'b0);

    // vector table
    for (int v = 0; v < 7; v++) begin
      drive_a(vecs[v].mask, {$urandom, $urandom, $urandom, $urandom});
      cnt = 0; first = -1; last = -1; n = 0;
      while (a_valid_out && n < 20) begin
        @(negedge clk);
        if (a_valid_out && a_ready_out) begin
          if (cnt == 0) first = int'(a_lane);
          last = int'(a_lane);
          cnt++;
        end
        tick();
        n++;
      end
      check("tv_beats", cnt, vecs[v].exp_beats);
      if (vecs[v].exp_beats > 0) begin
        check("tv_first_lane", first, vecs[v].exp_first);
        check("tv_last_lane", last, vecs[v].exp_last);
      end
    end

    // randomized run on both wide instances
    a_rnd_mode = 1'b1;
    fork
      begin
        for (int r = 0; r < 40; r++) begin
          logic [3:0]   m;
          logic [127:0] d;
          m = 4'($urandom_range(0, 15));
          d = {$urandom, $urandom, $urandom, $urandom};
          repeat ($urandom_range(0, 2)) tick();
          drive_a(m, d);
        end
      end
      begin
        for (int r = 0; r < 20; r++) begin
          logic [7:0]   m;
          logic [255:0] d;
          m = (r % 5 == 0) ? 8'hFF : 8'($urandom_range(0, 255));
          for (int i = 0; i < 8; i++) d[i*DW +: DW] = $urandom;
          repeat ($urandom_range(0, 2)) tick();
          drive_b(m, d);
        end
      end
    join

    n = 0;
    while ((a_exp_q.size() != 0 || b_exp_q.size() != 0) && n < 1000) begin
      tick();
      n++;
    end
    check("drain_a", a_exp_q.size(), 0);
    check("drain_b", b_exp_q.size(), 0);
    tick();
    check("final_idle", {a_valid_out, b_valid_out}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_lane_serializer.md
Name: vx_lane_serializer

Overview:
- Takes one multi-lane request (per-lane data plus active-lane mask) and emits the active lanes one per beat, lowest lane first, over a valid/ready stream.
- Sits downstream of the library prefix-scan. An OR-scan of the pending mask isolates the next active lane.
- Used where a per-lane resource is single-ported, such as serialized CSR, atomic or shared-port paths.

Parameters:
- NUM_LANES, 4, number of input lanes (>=1).
- DATA_WIDTH, 32, bits per lane.
- LANE_BITS, derived `$clog2(NUM_LANES)` (1 when NUM_LANES==1), width of the lane index and beat counter.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  input request valid.
- mask_in  in  NUM_LANES  active-lane mask.
- data_in  in  NUM_LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- ready_in  out  1  block accepts the request this cycle.
- valid_out  out  1  output beat valid.
- data_out  out  DATA_WIDTH  data of the selected lane.
- lane_out  out  LANE_BITS  index of the selected lane.
- beat_out  out  LANE_BITS  beat number within the request, starting at 0.
- sop_out  out  1  first beat of the request.
- eop_out  out  1  last beat of the request.
- ready_out  in  1  downstream accepts the beat.

Behaviour:
- Clock and reset: single clock clk. Reset reset_n is asynchronous and active-low.
- Reset values: busy=0, pending=0, beat=0, data register=0.
- Output values during reset:
  - valid_out=0, sop_out=0, eop_out=0, lane_out=0, beat_out=0, data_out=0.
  - ready_in=0 while reset_n is low; ready_in=1 from the first cycle after release.
- Handshakes:
  - fire_in = valid_in & ready_in.
  - fire_out = valid_out & ready_out.
  - last_fire = fire_out & eop_out.
- States, as a two-state FSM:
  - IDLE (busy=0): ready_in=1, valid_out=0.
  - BUSY (busy=1): valid_out=1, ready_in=last_fire. This allows back-to-back requests with no bubble.
- Acceptance: on fire_in with mask_in != 0:
  - Register mask_in into pending and data_in into the data register.
  - Set beat=0 and go to BUSY.
  - First beat is valid the next cycle, so latency is 1 cycle.
- Zero mask: on fire_in with mask_in == 0, the request is consumed and dropped. No beats are emitted and the state stays or becomes IDLE.
- Lane select, combinational from pending:
  - prefix = OR-scan of pending, LO->HI.
  - onehot = prefix & ~(prefix << 1).
  - lane_out = binary encode of onehot.
  - data_out = data register slice for lane_out.
- Beat outputs:
  - eop_out = busy & ((pending & ~onehot) == 0).
  - sop_out = busy & (beat == 0).
  - beat_out = beat.
- On fire_out without eop:
  - pending &= ~onehot and beat += 1.
  - beat never wraps, because it is at most popcount-1 <= NUM_LANES-1.
- On last_fire:
  - With a simultaneous fire_in with nonzero mask: load the new request and stay BUSY.
  - Otherwise: go to IDLE and clear pending and beat.
- Backpressure: with ready_out=0, all outputs hold stable. data_out, lane_out, sop_out and eop_out must not change while valid_out=1 and the beat is not accepted.
- valid_in while BUSY and not last_fire: not accepted. The upstream must hold its request.
- Reset mid-request: pending is discarded and no further beats are emitted. After release the block is IDLE.
- NUM_LANES==1: every nonzero request produces exactly one beat with sop_out=eop_out=1 and lane_out=0.
- No combinational path from valid_in or data_in to any output. ready_in depends combinationally on ready_out, through last_fire only.

Decomposition:
- No package types needed. LANE_BITS is a local parameter.
- One library sub-module instance: VX_scan with N=NUM_LANES, OP=2 (OR), REVERSE=0, producing prefix.
- The one-hot to binary step uses the existing one-hot encoder library block.
- The rest is inline registers and an output mux.

Test Plan:
1. Single request, no backpressure. NUM_LANES=4, mask_in=4'b1011, data lanes {0xD3,0xC2,0xB1,0xA0}, ready_out=1.
   -> 3 beats on consecutive cycles starting 1 cycle after accept: (lane 0, 0xA0, beat 0, sop=1), (lane 1, 0xB1, beat 1), (lane 3, 0xD3, beat 2, eop=1).
   -> ready_in=1 in the eop cycle.
2. Backpressure. mask_in=4'b0110, ready_out toggles 0,0,1,0,1.
   -> Lane 1 is held stable for 3 cycles, then lane 2 is held 2 cycles with eop=1.
   -> Exactly 2 beats are accepted and no duplicates occur.
3. Back-to-back requests. Request A mask 4'b1000; request B mask 4'b0001 presented during A's eop cycle.
   -> B is accepted on A's last_fire.
   -> Lane 3 of A is followed the next cycle by lane 0 of B with sop=1, eop=1.
4. Zero mask. mask_in=4'b0000 with valid_in=1.
   -> Accepted (ready_in=1) and valid_out stays 0.
   -> A following request with mask 4'b0100 emits a single beat, lane 2.
5. Reset mid-request. mask_in=4'b1111, reset_n pulled low asynchronously after the 2nd beat.
   -> valid_out=0 immediately and ready_in=0 during reset.
   -> After release: IDLE, ready_in=1, no residual beats.
6. Full mask, random stress against a reference model. NUM_LANES=8, mask_in=8'hFF, random ready_out.
   -> 8 beats, lane_out=beat_out=0..7 in order.
   -> sop only on the first beat, eop only on the last.
